fifo_sync_fwft: RTL

Parametrised single-clock first-word-fall-through FIFO built on inferred block RAM. It is the general buffer for the filter2d datapath: line buffers, pixel skew compensation and output elastic buffering. It adds configurable width and depth, full/empty and threshold flags, occupancy count, error pulses and a synchronous flush. The head word is always presented on `data_out` while `empty` is low. No vendor primitive is instantiated.

---
 rtl/fifo_sync_fwft.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fifo_sync_fwft.sv
// First-word-fall-through synchronous FIFO: registered head word in front of an
// inferred block RAM that holds the remaining words, with flags, count and error pulses.
module fifo_sync_fwft #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 2048,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  wre,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rde,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] fwd_data_reg;
    logic                  fwd_sel_reg;
    logic [DATA_WIDTH-1:0] ram_head;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
    logic          empty_reg, full_reg, aempty_reg, afull_reg;
    logic          overflow_reg, underflow_reg;

    logic wr_acc, rd_acc, ram_empty, ram_we, ram_pop;

    // The RAM beyond the head word is empty whenever at most one word is stored.
    assign ram_empty = (count_reg <= CW'(1));
    assign wr_acc    = wre && !full_reg && !clr;
    assign rd_acc    = rde && !empty_reg && !clr;
    assign ram_we    = wr_acc && !empty_reg && !(rd_acc && ram_empty);
    assign ram_pop   = rd_acc && !ram_empty;

    // A word written to the address being read this cycle is forwarded past the RAM.
    assign ram_head = fwd_sel_reg ? fwd_data_reg : ram_q;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        data_out_next = data_out_reg;
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (ram_we)
                wr_ptr_next = wr_ptr_reg + AW'(1);
            if (ram_pop)
                rd_ptr_next = rd_ptr_reg + AW'(1);
            count_next = count_reg + CW'(wr_acc) - CW'(rd_acc);
            if (ram_pop)
                data_out_next = ram_head;
            else if (wr_acc && (empty_reg || rd_acc))
                data_out_next = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[wr_ptr_reg] <= data_in;
        ram_q        <= mem[rd_ptr_next];
        fwd_data_reg <= data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            aempty_reg    <= 1'b1;
            afull_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            fwd_sel_reg   <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            data_out_reg  <= data_out_next;
            empty_reg     <= (count_next == '0);
            full_reg      <= (count_next == CW'(DEPTH));
            aempty_reg    <= (count_next <= AEMPTY_C);
            afull_reg     <= (count_next >= AFULL_C);
            overflow_reg  <= wre && full_reg && !clr;
            underflow_reg <= rde && empty_reg && !clr;
            fwd_sel_reg   <= ram_we && (wr_ptr_reg == rd_ptr_next);
        end
    end

    assign data_out     = data_out_reg;
    assign empty        = empty_reg;
    assign full         = full_reg;
    assign almost_empty = aempty_reg;
    assign almost_full  = afull_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule
